// File: rtl/comparator_fp_pkg.sv
// Shared fixed-point types and defaults for the comparator bank.
package comparator_fp_pkg;

  localparam int W_DEF    = 34;
  localparam int FRAC_DEF = 24;

  typedef logic signed [W_DEF-1:0] fp_t;
  typedef logic signed [W_DEF:0]   diff_t;

  // One extra bit keeps p - n exact for any pair of W-bit inputs.
  function automatic diff_t fp_sub_ext(input fp_t a, input fp_t b);
    return {a[W_DEF-1], a} - {b[W_DEF-1], b};
  endfunction

endpackage

// File: rtl/comparator_channel_fp.sv
// One comparator lane: widened difference, hysteresis band, debounce counter and output bit.
module comparator_channel_fp #(
  parameter int W        = 34,
  parameter int DEBOUNCE = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         sys_clk,
  input  logic [W-1:0] p_i,
  input  logic [W-1:0] n_i,
  input  logic [W-2:0] hyst_i,
  output logic         out_o,
  output logic         toggle_o
);

  localparam int CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

  logic signed [W:0] diff;
  logic signed [W:0] hyst_pos;
  logic signed [W:0] hyst_neg;
  logic              raw;
  logic              out_q, out_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              toggle;

  assign diff     = $signed({p_i[W-1], p_i}) - $signed({n_i[W-1], n_i});
  assign hyst_pos = $signed({2'b00, hyst_i});
  assign hyst_neg = -hyst_pos;
  // The threshold depends on the current output, so equality with the band edge holds state.
  assign raw      = out_q ? !(diff < hyst_neg) : (diff > hyst_pos);

  always_comb begin
    out_d  = out_q;
    cnt_d  = cnt_q;
    toggle = 1'b0;
    if (sys_clk) begin
      if (raw == out_q) begin
        cnt_d = '0;
      end else if (cnt_q == CW'(DEBOUNCE - 1)) begin
        out_d  = ~out_q;
        cnt_d  = '0;
        toggle = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      out_q <= out_d;
      cnt_q <= cnt_d;
    end
  end

  assign out_o    = out_q;
  assign toggle_o = toggle;

endmodule

// File: rtl/comparator_bank_fp.sv
// N_CH debounced fixed-point comparators; output changes are queued as pending flags
// and drained one per cycle through a round-robin valid/ready event register.
module comparator_bank_fp
  import comparator_fp_pkg::*;
#(
  parameter int N_CH     = 4,
  parameter int W        = W_DEF,
  parameter int FRAC     = FRAC_DEF,
  parameter int DEBOUNCE = 3,
  localparam int CHW     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sys_clk,
  input  logic [N_CH*W-1:0] p_voltage_real,
  input  logic [N_CH*W-1:0] n_voltage_real,
  input  logic [W-2:0]      hyst,
  output logic [N_CH-1:0]   out_digital,
  output logic              evt_valid,
  input  logic              evt_ready,
  output logic [CHW-1:0]    evt_channel,
  output logic              evt_level,
  output logic              evt_lost,
  input  logic              lost_clr
);

  if (FRAC >= W) begin : g_frac_range
    $error("FRAC must be smaller than W");
  end

  logic [N_CH-1:0] toggle;
  logic [N_CH-1:0] pending_q, pending_d;
  logic [N_CH-1:0] gnt_oh;
  logic [CHW-1:0]  rr_q, rr_d;
  logic [CHW-1:0]  gnt_ch, idx;
  logic            gnt_vld, load;
  logic            evt_valid_q, evt_valid_d;
  logic [CHW-1:0]  evt_ch_q, evt_ch_d;
  logic            evt_lvl_q, evt_lvl_d;
  logic            lost_q, lost_d;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    comparator_channel_fp #(.W(W), .DEBOUNCE(DEBOUNCE)) u_ch (
      .clk      (clk),
      .rst_n    (reset),
      .sys_clk  (sys_clk),
      .p_i      (p_voltage_real[i*W +: W]),
      .n_i      (n_voltage_real[i*W +: W]),
      .hyst_i   (hyst),
      .out_o    (out_digital[i]),
      .toggle_o (toggle[i])
    );
  end

  // Walk from the farthest candidate inwards so the nearest one after rr_q wins.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_ch  = '0;
    idx     = '0;
    for (int k = N_CH; k >= 1; k--) begin
      idx = CHW'((int'(rr_q) + k) % N_CH);
      if (pending_q[idx]) begin
        gnt_vld = 1'b1;
        gnt_ch  = idx;
      end
    end
  end

  assign load = gnt_vld && (!evt_valid_q || evt_ready);

  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      gnt_oh[i] = load && (gnt_ch == CHW'(i));
    end
  end

  always_comb begin
    pending_d   = (pending_q & ~gnt_oh) | toggle;
    lost_d      = (|(toggle & pending_q & ~gnt_oh)) | (lost_q & ~lost_clr);
    evt_valid_d = evt_valid_q;
    evt_ch_d    = evt_ch_q;
    evt_lvl_d   = evt_lvl_q;
    rr_d        = rr_q;
    if (load) begin
      evt_valid_d = 1'b1;
      evt_ch_d    = gnt_ch;
      evt_lvl_d   = out_digital[gnt_ch];
      rr_d        = gnt_ch;
    end else if (evt_ready) begin
      evt_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending_q   <= '0;
      rr_q        <= CHW'(N_CH - 1);
      evt_valid_q <= 1'b0;
      evt_ch_q    <= '0;
      evt_lvl_q   <= 1'b0;
      lost_q      <= 1'b0;
    end else begin
      pending_q   <= pending_d;
      rr_q        <= rr_d;
      evt_valid_q <= evt_valid_d;
      evt_ch_q    <= evt_ch_d;
      evt_lvl_q   <= evt_lvl_d;
      lost_q      <= lost_d;
    end
  end

  assign evt_valid   = evt_valid_q;
  assign evt_channel = evt_ch_q;
  assign evt_level   = evt_lvl_q;
  assign evt_lost    = lost_q;

endmodule

// File: tb/tb_comparator_bank_fp.sv
// Directed bench for comparator_bank_fp with an event scoreboard.
module tb_comparator_bank_fp;

  localparam int N   = 4;
  localparam int WW  = 34;
  localparam logic [WW-1:0] ONE  = 34'h0_0100_0000;
  localparam logic [WW-1:0] ZERO = 34'h0;
  localparam logic [WW-1:0] MAXP = 34'h1_FFFF_FFFF;
  localparam logic [WW-1:0] MINN = 34'h2_0000_0000;

  typedef struct packed { logic [1:0] ch; logic lvl; } exp_t;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            sys_clk;
  logic [N*WW-1:0] p_v, n_v;
  logic [WW-2:0]   hyst;
  logic [N-1:0]    out_digital;
  logic            evt_valid, evt_ready, evt_level, evt_lost, lost_clr;
  logic [1:0]      evt_channel;

  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  exp_t sb[$];
  int   cyc_q[$];
  exp_t e;

  comparator_bank_fp #(.N_CH(N), .W(WW), .FRAC(24), .DEBOUNCE(3)) dut (
    .clk            (clk),
    .reset          (rst_n),
    .sys_clk        (sys_clk),
    .p_voltage_real (p_v),
    .n_voltage_real (n_v),
    .hyst           (hyst),
    .out_digital    (out_digital),
    .evt_valid      (evt_valid),
    .evt_ready      (evt_ready),
    .evt_channel    (evt_channel),
    .evt_level      (evt_level),
    .evt_lost       (evt_lost),
    .lost_clr       (lost_clr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Accepted events are compared against the scoreboard on the negedge before the handshake edge.
  always @(negedge clk) begin
    if (rst_n && evt_valid && evt_ready) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $error("FAIL evt_unexpected: got ch=%0d lvl=%0b required no event", evt_channel, evt_level);
      end else begin
        e = sb.pop_front();
        assert ({evt_channel, evt_level} === {e.ch, e.lvl}) else begin
          fails++;
          $error("FAIL evt: got ch=%0d lvl=%0b required ch=%0d lvl=%0b",
                 evt_channel, evt_level, e.ch, e.lvl);
        end
        cyc_q.push_back(cyc);
      end
    end
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic strobe(input int n);
    for (int i = 0; i < n; i++) begin
      sys_clk = 1'b1;
      tick(1);
      sys_clk = 1'b0;
      tick(3);
    end
  endtask

  task automatic set_ch(input int ch, input logic [WW-1:0] p, input logic [WW-1:0] n);
    p_v[ch*WW +: WW] = p;
    n_v[ch*WW +: WW] = n;
  endtask

  task automatic push(input logic [1:0] ch, input logic lvl);
    exp_t x;
    x.ch  = ch;
    x.lvl = lvl;
    sb.push_back(x);
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h required %0h", tag, got, exp);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    sys_clk   = 1'b0;
    p_v       = '0;
    n_v       = '0;
    hyst      = 33'h0_0019_9999;
    evt_ready = 1'b1;
    lost_clr  = 1'b0;
    tick(2);
    check("rst_out", 64'(out_digital), 64'h0);
    check("rst_valid", 64'(evt_valid), 64'h0);
    check("rst_chan", 64'(evt_channel), 64'h0);
    check("rst_level", 64'(evt_level), 64'h0);
    check("rst_lost", 64'(evt_lost), 64'h0);
    rst_n = 1'b1;
    tick(2);

    // Basic rise on channel 0 after three strobes.
    set_ch(0, ONE, ZERO);
    strobe(2);
    check("rise_early", 64'(out_digital), 64'h0);
    push(2'd0, 1'b1);
    strobe(1);
    check("rise", 64'(out_digital), 64'h1);
    tick(2);

    // Inside the band the output holds; beyond it, it falls.
    set_ch(0, ZERO, 34'h0_0010_0000);
    strobe(10);
    check("hyst_hold", 64'(out_digital[0]), 64'h1);
    set_ch(0, ZERO, 34'h0_0020_0000);
    push(2'd0, 1'b0);
    strobe(2);
    check("fall_early", 64'(out_digital[0]), 64'h1);
    strobe(1);
    check("fall", 64'(out_digital[0]), 64'h0);
    tick(2);

    // Alternating samples keep resetting the debounce counter.
    for (int i = 0; i < 4; i++) begin
      set_ch(0, ONE, ZERO);
      strobe(1);
      set_ch(0, ZERO, ONE);
      strobe(1);
    end
    check("alt_hold", 64'(out_digital), 64'h0);
    check("alt_no_evt", 64'(sb.size()), 64'h0);
    set_ch(0, ZERO, ZERO);

    // Three simultaneous flips drain on consecutive cycles in channel order.
    cyc_q.delete();
    set_ch(1, ONE, ZERO);
    set_ch(2, ONE, ZERO);
    set_ch(3, ONE, ZERO);
    push(2'd1, 1'b1);
    push(2'd2, 1'b1);
    push(2'd3, 1'b1);
    strobe(3);
    tick(3);
    check("rr_out", 64'(out_digital), 64'he);
    check("rr_count", 64'(cyc_q.size()), 64'd3);
    if (cyc_q.size() == 3) begin
      check("rr_b2b_a", 64'(cyc_q[1] - cyc_q[0]), 64'd1);
      check("rr_b2b_b", 64'(cyc_q[2] - cyc_q[1]), 64'd1);
    end

    // Held event with ready low, then the pointer continues after channel 1.
    evt_ready = 1'b0;
    set_ch(1, ZERO, ONE);
    push(2'd1, 1'b0);
    strobe(3);
    check("held_valid", 64'(evt_valid), 64'h1);
    check("held_chan", 64'(evt_channel), 64'h1);
    check("held_level", 64'(evt_level), 64'h0);
    evt_ready = 1'b1;
    tick(2);
    set_ch(0, ONE, ZERO);
    set_ch(2, ZERO, ONE);
    push(2'd2, 1'b0);
    push(2'd0, 1'b1);
    strobe(3);
    tick(3);
    check("ptr_out", 64'(out_digital), 64'h9);

    // Loss: register occupied by ch3, then ch2 flips twice while pending.
    evt_ready = 1'b0;
    set_ch(3, ZERO, ONE);
    push(2'd3, 1'b0);
    strobe(3);
    set_ch(2, ONE, ZERO);
    strobe(3);
    check("lost_before", 64'(evt_lost), 64'h0);
    set_ch(2, ZERO, ONE);
    strobe(3);
    check("lost_set", 64'(evt_lost), 64'h1);
    check("lost_hold_chan", 64'(evt_channel), 64'h3);
    push(2'd2, 1'b0);
    evt_ready = 1'b1;
    tick(4);
    check("lost_sticky", 64'(evt_lost), 64'h1);
    lost_clr = 1'b1;
    tick(1);
    lost_clr = 1'b0;
    check("lost_clr", 64'(evt_lost), 64'h0);

    // Extremes: the widened difference stays positive.
    set_ch(3, MAXP, MINN);
    push(2'd3, 1'b1);
    strobe(3);
    tick(2);
    check("ovf_rise", 64'(out_digital[3]), 64'h1);

    // Reset in the middle of a debounce run restarts the count.
    set_ch(0, ZERO, ZERO);
    set_ch(2, ZERO, ZERO);
    set_ch(3, ZERO, ZERO);
    set_ch(1, ONE, ZERO);
    strobe(2);
    check("mid_out", 64'(out_digital), 64'h9);
    rst_n = 1'b0;
    tick(2);
    check("mid_rst_out", 64'(out_digital), 64'h0);
    check("mid_rst_valid", 64'(evt_valid), 64'h0);
    rst_n = 1'b1;
    tick(1);
    strobe(2);
    check("post_rst_early", 64'(out_digital), 64'h0);
    push(2'd1, 1'b1);
    strobe(1);
    check("post_rst_rise", 64'(out_digital), 64'h2);
    tick(4);
    check("sb_empty", 64'(sb.size()), 64'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/comparator_bank_fp.md
Name: comparator_bank_fp

Overview:
Parametrised multi-channel successor to the single fixed-point comparator. Compares N_CH signed fixed-point p/n voltage pairs on each sys_clk sample strobe, with programmable hysteresis and per-channel debounce. Per-channel output-change events are queued as pending flags and drained through a round-robin valid/ready event port. Sits between the fixed-point analog models and digital control logic.

Parameters:
N_CH, 4, number of channels (>=1)
W, 34, signed fixed-point width of each voltage
FRAC, 24, fractional bits (1.0 = 2^FRAC); informational, no arithmetic effect
DEBOUNCE, 3, consecutive disagreeing samples required to flip an output (>=1)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
sys_clk  in  1  sample strobe, sampled high on a clk rising edge
p_voltage_real  in  N_CH*W  packed signed positive inputs; channel i at bits [i*W +: W]
n_voltage_real  in  N_CH*W  packed signed negative inputs, same packing
hyst  in  W-1  unsigned hysteresis half-width, same scale as voltages
out_digital  out  N_CH  debounced comparator outputs
evt_valid  out  1  event available
evt_ready  in  1  consumer accepts event
evt_channel  out  max(1,$clog2(N_CH))  channel index of event
evt_level  out  1  channel level captured when event loaded
evt_lost  out  1  sticky: a change was overwritten while still pending
lost_clr  in  1  clears evt_lost

Behaviour:
- Reset asserted: out_digital, evt_valid, evt_channel, evt_level, evt_lost, debounce counters and pending flags all 0, asynchronously. RR pointer = N_CH-1, so the first search starts at channel 0.
- Difference per channel: diff = p - n, computed at W+1 bits with no saturation.
- Raw decision, relative to current out: out=0 -> raw=1 iff diff > +hyst. out=1 -> raw=0 iff diff < -hyst. Otherwise raw=out. hyst=0: equality holds the current state.
- Debounce: evaluated only on cycles with sys_clk=1.
  - raw==out: counter cleared.
  - raw!=out with counter==DEBOUNCE-1: out toggles, counter cleared.
  - raw!=out otherwise: counter increments.
  - With sys_clk=0, counters and out hold.
- Latency: the flip is visible the clk edge after the DEBOUNCE-th qualifying sample.
- Pending: set for channel i when out_digital[i] toggles.
- Loss: if pending[i] is already 1 and not being granted that cycle, a new toggle sets evt_lost.
- Simultaneous grant and toggle on the same channel: pending stays 1, no loss.
- lost_clr clears evt_lost. A simultaneous set wins.
- Event register loads when (!evt_valid || evt_ready) and any pending bit is set:
  - Grant goes to the first pending channel searching from pointer+1 mod N_CH.
  - Loads evt_channel and evt_level = current out_digital[ch].
  - Clears pending[ch], sets pointer = ch, sets evt_valid=1.
- If no pending bit is set and evt_ready=1: evt_valid falls to 0.
- evt_valid=1 with evt_ready=0: evt_channel and evt_level hold stable.
- Back-to-back: one event per cycle while evt_ready=1.

Decomposition:
- Package comparator_fp_pkg: W and FRAC defaults, fp_t typedef (signed [W-1:0]), diff_t typedef (signed [W:0]), fp_sub_ext function.
- Sub-module comparator_channel_fp: holds diff, hysteresis, debounce counter and out bit. Outputs out and a toggle pulse. Generated N_CH times.
- The top level holds the pending flags, round-robin arbiter and event register.

Test Plan:
- Reset sequence -> all outputs 0. Then ch0 p=0x1000000 (1.0), n=0, hyst=0x199999 (~0.1), DEBOUNCE=3, sys_clk every 4th cycle -> out_digital[0] rises 1 clk after the 3rd strobe; event ch=0, level=1.
- Hysteresis: out[0]=1; diff=-0x100000 (inside band), 10 strobes -> out holds 1. diff=-0x200000 -> out falls after 3 strobes.
- Debounce reset: diff alternates above/below band on each strobe -> out never toggles and no events.
- Round robin: ch1, ch2 and ch3 flip on the same cycle with evt_ready=1 -> events ch1, ch2, ch3 on consecutive cycles.
- Then ch1 flips again with evt_ready held 0 -> next event ch1. Confirm pointer continues from 1.
- Loss: evt_ready=0, ch2 flips twice -> evt_lost=1 and only one ch2 event is reported. lost_clr -> evt_lost=0.
- Overflow edge: p=most positive, n=most negative -> diff positive, out rises.
- Assert reset mid-debounce (counter=2) -> counter 0; the flip needs a full 3 samples after release.
